imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a byte stream (16-bit LE word count, then LE words),
// writes instruction memory and holds the core in reset until done. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR
`ifdef LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    // Largest legal word count; 17 bits so ADDR_WIDTH=16 still fits.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                  state, state_d, tail_state;
    logic [7:0]              cnt_lo;
    logic [15:0]             word_cnt;
    logic [15:0]             hdr_n;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [1:0]              byte_idx;
    logic [31:0]             asm_word;
    logic                    fire;
    logic                    last_word;

    assign fire      = in_valid & in_ready;
    assign hdr_n     = {in_data, cnt_lo};
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, word_cnt};
    assign imem_addr  = word_idx;
    assign imem_wdata = asm_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;
    assign tail_state = CHK;
`else
    assign tail_state = DONE;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        core_rst = 1'b1;
        case (state)
            IDLE: if (start) state_d = HDR0;
            HDR0: begin
                in_ready = 1'b1;
                if (in_valid) state_d = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_n == 16'd0)                 state_d = tail_state;
                    else if ({1'b0, hdr_n} > CAPACITY)  state_d = ERR;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                imem_we = 1'b1;
                state_d = last_word ? tail_state : DATA;
            end
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b0;
                if (start) state_d = HDR0;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_d = HDR0;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_data == chk_acc) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: only control/datapath registers are reset; the instruction memory itself is never cleared here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_lo   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        cnt_lo   <= '0;
                        word_cnt <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        asm_word <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc  <= '0;
`endif
                    end
                end
                HDR0: if (fire) cnt_lo <= in_data;
                HDR1: if (fire) word_cnt <= hdr_n;
                DATA: begin
                    if (fire) begin
                        asm_word[8*byte_idx +: 8] <= in_data;
                        byte_idx                  <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_acc                   <= chk_acc ^ in_data;
`endif
                    end
                end
                // Index stops at the final word so it never wraps past the top address.
                WRITE: if (!last_word) word_idx <= word_idx + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule
